uart_tx_ctl: RTL and testbench
==============================

Name: uart_tx_ctl

Overview:
UART transmitter controller; the transmit-side counterpart of the UART receiver controller.
Accepts one 8-bit character per valid/ready handshake and serialises it on txd as START, 8 data bits LSB first, optional parity and STOP.
Bit timing comes from the shared 16x oversampling enable produced by the baud rate generator.
Sits in uart_tx, between the character source (FIFO/command response logic) and the output pin register.

Parameters:
NUM_STOP, 1, number of STOP bits (legal: 1 or 2)
PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd); ignored otherwise

Ports:
clk_tx  input  1  clock
rst_clk_tx  input  1  reset; synchronous to clk_tx, active high
baud_x16_en  input  1  16x oversampling enable, one clk_tx cycle wide
tx_data  input  8  character to send
tx_data_vld  input  1  tx_data is valid
tx_data_rdy  output  1  block can accept a character
txd_tx  output  1  serial output, registered, idle high
tx_busy  output  1  a character is in flight (state != IDLE)

Behaviour:
- Reset: state=IDLE, txd_tx=1, tx_data_rdy=1, tx_busy=0, over_sample_cnt=0, bit_cnt=0, shift register=0.
- Reset mid-character: at the next clk_tx edge, txd_tx returns to 1 and the character is abandoned; no partial bits resume.
- tx_data_rdy is registered and equals (state==IDLE).
- Handshake: a transfer occurs on any clk_tx edge where tx_data_vld && tx_data_rdy; it does not depend on baud_x16_en.
  - On that edge: tx_data is latched into the shift register, state becomes START, txd_tx becomes 0, over_sample_cnt is loaded with 15, tx_data_rdy becomes 0.
  - tx_data_vld while not ready is ignored; the upstream source holds its data.
- Bit timing:
  - over_sample_cnt decrements only on baud_x16_en.
  - A bit ends on a baud_x16_en cycle where over_sample_cnt==0; at that edge the counter reloads 15 and the next bit is driven.
  - Every bit therefore spans exactly 16 baud_x16_en pulses after entry.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - START: at bit end -> DATA; txd_tx=shift[0]; bit_cnt=0.
  - DATA: at bit end, if bit_cnt==7 -> PARITY (when compiled in) or STOP; otherwise shift right, bit_cnt++, txd_tx=next LSB.
  - PARITY: at bit end -> STOP; txd_tx=1.
  - STOP: txd_tx=1; stop_cnt counts NUM_STOP bit periods; at the last bit end -> IDLE, tx_data_rdy=1.
  - Back-to-back characters: a new transfer may occur on the cycle after IDLE is re-entered; there is no extra idle bit.
- Frame length: 10 bits (1 stop, no parity) to 12 bits (2 stop, parity), each bit 16 enables.
- bit_cnt is 3 bits and wraps only through explicit reset to 0 in START.
- Multicycle: all FSM/counter flops advance only on baud_x16_en, except the handshake load path, which is single-cycle.

Optional Feature:
UART_TX_PARITY_EN.
- Defined: PARITY state is inserted after DATA.
  - Parity bit = XOR of the 8 latched data bits, inverted when PARITY_ODD=1.
  - Parity is computed at the handshake edge and held in a flop.
- Undefined: PARITY state and parity flop are absent; DATA goes directly to STOP; PARITY_ODD has no effect.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: 3-bit localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - OVERSAMPLE=16 and DATA_BITS=8 constants, shared with the receiver.
- One natural sub-module, uart_bit_timer: the 4-bit oversample counter with load-15 and done output.
  - Reusable by the receiver refactor (the receiver additionally needs load-7).

Test Plan:
- Send 8'hA5, baud_x16_en every 4 clk_tx, NUM_STOP=1, no parity -> txd_tx reads 0,1,0,1,0,0,1,0,1,1 (LSB first), each bit 16 enables; tx_data_rdy rises after 160 enables.
- Send 8'h00 then 8'hFF with tx_data_vld held continuously -> two frames back-to-back, second START begins 1 clk after IDLE; no idle gap beyond that cycle.
- NUM_STOP=2, send 8'h3C -> STOP held high for 32 enables; total frame 176 enables.
- UART_TX_PARITY_EN defined:
  - PARITY_ODD=0, send 8'h07 -> parity bit 1;
  - PARITY_ODD=1, send 8'h07 -> parity bit 0;
  - frame 11 bits.
- Assert rst_clk_tx during DATA bit 4 -> next edge txd_tx=1, tx_data_rdy=1, tx_busy=0; next character is sent cleanly.
- tx_data_vld pulsed while tx_busy=1 with 8'h55 -> ignored; the in-flight character is unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and transmit FSM state encoding, common to the tx and rx controllers.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_START  = START,
        ST_DATA   = DATA,
        ST_PARITY = PARITY,
        ST_STOP   = STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_ctl_if.sv
// Character handshake between the character source and the UART transmitter.
// Source drives tx_data/tx_data_vld and holds them until tx_data_rdy is seen.
interface uart_tx_ctl_if;
    logic [7:0] tx_data;
    logic       tx_data_vld;
    logic       tx_data_rdy;

    modport master (output tx_data, output tx_data_vld, input tx_data_rdy);
    modport slave  (input tx_data, input tx_data_vld, output tx_data_rdy);
endinterface

// File: rtl/uart_bit_timer.sv
// Oversample bit timer: done pulses on the enable that closes each 16-enable bit period.
// Load has priority over tick; no backpressure.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic clk_tx,
    input  logic rst_clk_tx,
    input  logic tick,
    input  logic run,
    input  logic load,
    output logic done
);

    localparam int            CW     = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] RELOAD = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_tx) begin
        if (rst_clk_tx) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= RELOAD;
        end else if (run && tick) begin
            cnt_q <= (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
        end
    end

    assign done = run && tick && !load && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ctl.sv
// UART transmit controller: START, 8 data LSB first, optional parity (UART_TX_PARITY_EN), NUM_STOP stops.
// Accepts one character per handshake only while idle; tx_data_rdy is low for the whole frame.
module uart_tx_ctl
    import uart_pkg::*;
#(
    parameter int NUM_STOP   = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk_tx,
    input  logic         rst_clk_tx,
    input  logic         baud_x16_en,
    uart_tx_ctl_if.slave tx_if,
    output logic         txd_tx,
    output logic         tx_busy
);

    if (NUM_STOP != 1 && NUM_STOP != 2) begin : g_bad_num_stop
        $error("uart_tx_ctl: NUM_STOP must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_ctl: PARITY_ODD must be 0 or 1");
    end

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(NUM_STOP - 1);

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        txd_q, txd_d;
    logic        rdy_q, rdy_d;
    logic        load;
    logic        bit_done;
    logic        accept;

`ifdef UART_TX_PARITY_EN
    localparam logic ODD_BIT = (PARITY_ODD != 0);
    logic par_q, par_d;
`endif

    assign accept            = tx_if.tx_data_vld && rdy_q;
    assign tx_if.tx_data_rdy = rdy_q;
    assign txd_tx            = txd_q;
    assign tx_busy           = (state_q != ST_IDLE);

    uart_bit_timer u_bit_timer (
        .clk_tx     (clk_tx),
        .rst_clk_tx (rst_clk_tx),
        .tick       (baud_x16_en),
        .run        (tx_busy),
        .load       (load),
        .done       (bit_done)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        load       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    state_d = ST_START;
                    shift_d = tx_if.tx_data;
                    txd_d   = 1'b0;
                    load    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^tx_if.tx_data) ^ ODD_BIT;
`endif
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    txd_d     = shift_q[0];
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d    = ST_PARITY;
                        txd_d      = par_q;
`else
                        state_d    = ST_STOP;
                        txd_d      = 1'b1;
                        stop_cnt_d = 1'b0;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d    = ST_STOP;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_done) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_tx) begin
        if (rst_clk_tx) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            rdy_q      <= rdy_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk_tx) begin
        if (rst_clk_tx) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Directed bench for uart_tx_ctl: frame bits sampled mid-bit, enable counts to tx_data_rdy, reset and busy behaviour.
`timescale 1ns/1ps
module tb_uart_tx_ctl;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk_tx = 1'b0;
    logic       rst_clk_tx;
    logic       baud_x16_en;
    logic [7:0] data_r;
    logic       vld_r;
    int         sel;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic txd1, txd2, txd3, busy1, busy2, busy3;
    logic txd_m, rdy_m, busy_m;

    uart_tx_ctl_if if1 ();
    uart_tx_ctl_if if2 ();
    uart_tx_ctl_if if3 ();

    assign if1.tx_data     = data_r;
    assign if2.tx_data     = data_r;
    assign if3.tx_data     = data_r;
    assign if1.tx_data_vld = vld_r && (sel == 0);
    assign if2.tx_data_vld = vld_r && (sel == 1);
    assign if3.tx_data_vld = vld_r && (sel == 2);

    uart_tx_ctl #(.NUM_STOP(1), .PARITY_ODD(0)) dut1 (
        .clk_tx(clk_tx), .rst_clk_tx(rst_clk_tx), .baud_x16_en(baud_x16_en),
        .tx_if(if1), .txd_tx(txd1), .tx_busy(busy1)
    );
    uart_tx_ctl #(.NUM_STOP(2), .PARITY_ODD(0)) dut2 (
        .clk_tx(clk_tx), .rst_clk_tx(rst_clk_tx), .baud_x16_en(baud_x16_en),
        .tx_if(if2), .txd_tx(txd2), .tx_busy(busy2)
    );
    uart_tx_ctl #(.NUM_STOP(1), .PARITY_ODD(1)) dut3 (
        .clk_tx(clk_tx), .rst_clk_tx(rst_clk_tx), .baud_x16_en(baud_x16_en),
        .tx_if(if3), .txd_tx(txd3), .tx_busy(busy3)
    );

    always_comb begin
        case (sel)
            1:       begin txd_m = txd2; rdy_m = if2.tx_data_rdy; busy_m = busy2; end
            2:       begin txd_m = txd3; rdy_m = if3.tx_data_rdy; busy_m = busy3; end
            default: begin txd_m = txd1; rdy_m = if1.tx_data_rdy; busy_m = busy1; end
        endcase
    end

    always #5 clk_tx = ~clk_tx;

    // Enable once every 4 clocks, changed just after the edge so it is stable at negedge.
    initial begin
        int div;
        div = 0;
        baud_x16_en = 1'b0;
        forever begin
            @(posedge clk_tx);
            #1;
            baud_x16_en = (div == 3);
            div = (div + 1) % 4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic use_dut(input int k);
        sel = k;
        @(negedge clk_tx);
    endtask

    // Returns at the negedge following the handshake edge.
    task automatic send(input logic [7:0] d);
        int cyc;
        cyc = 0;
        @(negedge clk_tx);
        data_r = d;
        vld_r  = 1'b1;
        while (rdy_m !== 1'b1 && cyc < 5000) begin
            @(negedge clk_tx);
            cyc++;
        end
        chk("send_rdy", rdy_m, 1);
        @(negedge clk_tx);
        vld_r = 1'b0;
    endtask

    // Called at the negedge after a handshake; n counts enables consumed since then.
    task automatic capture(input int inj_at, output logic [11:0] frame, output int n);
        int cyc;
        bit inj;
        frame = '0;
        n     = 0;
        cyc   = 0;
        inj   = 1'b0;
        while (rdy_m !== 1'b1 && cyc < 4000) begin
            if (n % 16 == 8 && n / 16 < 12) frame[n / 16] = txd_m;
            if (inj_at >= 0 && n == inj_at && !inj) begin
                data_r = 8'h55;
                vld_r  = 1'b1;
                inj    = 1'b1;
            end else if (inj) begin
                vld_r = 1'b0;
            end
            if (baud_x16_en) n++;
            @(negedge clk_tx);
            cyc++;
        end
        chk("frame_rdy_rise", rdy_m, 1);
    endtask

    task automatic wait_en(input int k);
        int n;
        int cyc;
        n   = 0;
        cyc = 0;
        while (n < k && cyc < 5000) begin
            if (baud_x16_en) n++;
            @(negedge clk_tx);
            cyc++;
        end
        chk("wait_en", n, k);
    endtask

    initial begin
        logic [11:0] fr;
        int          n;

        rst_clk_tx = 1'b1;
        data_r     = 8'h00;
        vld_r      = 1'b0;
        sel        = 0;
        repeat (4) @(negedge clk_tx);
        rst_clk_tx = 1'b0;

        for (int k = 0; k < 3; k++) begin
            use_dut(k);
            chk("rst_txd", txd_m, 1);
            chk("rst_rdy", rdy_m, 1);
            chk("rst_busy", busy_m, 0);
        end

        // 8'hA5 on the 1-stop instance
        use_dut(0);
        send(8'hA5);
        chk("a5_start_txd", txd_m, 0);
        chk("a5_busy", busy_m, 1);
        chk("a5_rdy_low", rdy_m, 0);
        capture(-1, fr, n);
`ifdef UART_TX_PARITY_EN
        chk("a5_frame", fr, {1'b1, 1'b0, 8'hA5, 1'b0});
`else
        chk("a5_frame", fr, {1'b1, 8'hA5, 1'b0});
`endif
        chk("a5_enables", n, 160 + 16 * PAR);
        chk("a5_idle_busy", busy_m, 0);
        chk("a5_idle_txd", txd_m, 1);

        // 8'h00 then 8'hFF with valid held throughout
        @(negedge clk_tx);
        data_r = 8'h00;
        vld_r  = 1'b1;
        @(negedge clk_tx);
        data_r = 8'hFF;
        chk("b2b0_start_txd", txd_m, 0);
        capture(-1, fr, n);
`ifdef UART_TX_PARITY_EN
        chk("b2b0_frame", fr, {1'b1, 1'b0, 8'h00, 1'b0});
`else
        chk("b2b0_frame", fr, {1'b1, 8'h00, 1'b0});
`endif
        chk("b2b0_enables", n, 160 + 16 * PAR);
        @(negedge clk_tx);
        chk("b2b1_start_txd", txd_m, 0);
        chk("b2b1_rdy_low", rdy_m, 0);
        chk("b2b1_busy", busy_m, 1);
        vld_r = 1'b0;
        capture(-1, fr, n);
`ifdef UART_TX_PARITY_EN
        chk("b2b1_frame", fr, {1'b1, 1'b0, 8'hFF, 1'b0});
`else
        chk("b2b1_frame", fr, {1'b1, 8'hFF, 1'b0});
`endif
        chk("b2b1_enables", n, 160 + 16 * PAR);

        // two stop bits
        use_dut(1);
        send(8'h3C);
        capture(-1, fr, n);
`ifdef UART_TX_PARITY_EN
        chk("stop2_frame", fr, {2'b11, 1'b0, 8'h3C, 1'b0});
`else
        chk("stop2_frame", fr, {2'b11, 8'h3C, 1'b0});
`endif
        chk("stop2_enables", n, 176 + 16 * PAR);

`ifdef UART_TX_PARITY_EN
        use_dut(0);
        send(8'h07);
        capture(-1, fr, n);
        chk("par_even_frame", fr, {1'b1, 1'b1, 8'h07, 1'b0});
        chk("par_even_enables", n, 176);
        use_dut(2);
        send(8'h07);
        capture(-1, fr, n);
        chk("par_odd_frame", fr, {1'b1, 1'b0, 8'h07, 1'b0});
        chk("par_odd_enables", n, 176);
`endif

        // reset in the middle of data bit 4 of 8'hC3 (bit 4 is 0)
        use_dut(0);
        send(8'hC3);
        wait_en(88);
        chk("rstmid_txd_before", txd_m, 0);
        chk("rstmid_busy_before", busy_m, 1);
        rst_clk_tx = 1'b1;
        @(negedge clk_tx);
        chk("rstmid_txd", txd_m, 1);
        chk("rstmid_rdy", rdy_m, 1);
        chk("rstmid_busy", busy_m, 0);
        rst_clk_tx = 1'b0;
        send(8'h5A);
        capture(-1, fr, n);
`ifdef UART_TX_PARITY_EN
        chk("after_rst_frame", fr, {1'b1, 1'b0, 8'h5A, 1'b0});
`else
        chk("after_rst_frame", fr, {1'b1, 8'h5A, 1'b0});
`endif
        chk("after_rst_enables", n, 160 + 16 * PAR);

        // 8'h55 offered while busy must not disturb 8'h0F
        send(8'h0F);
        capture(40, fr, n);
`ifdef UART_TX_PARITY_EN
        chk("busy_vld_frame", fr, {1'b1, 1'b0, 8'h0F, 1'b0});
`else
        chk("busy_vld_frame", fr, {1'b1, 8'h0F, 1'b0});
`endif
        chk("busy_vld_enables", n, 160 + 16 * PAR);
        @(negedge clk_tx);
        chk("busy_vld_idle", busy_m, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
